// File: rtl/loop_ctrl.sv
// loop_ctrl: sequencing controller for a counted dataflow loop.
// Accepts an iteration count N and issues the arbiter (choose_right) and demux
// (go_right) control tokens that make one data token circulate N times and
// then exit. A done token follows once the whole sequence has been issued.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   count_in                count token, [CNT_W]=valid, [CNT_W-1:0]=N
//   count_back_stop         stall to the count producer (combinational)
//   choose_right            arbiter token, [1]=valid, [0]=1 entry / 0 feedback
//   choose_right_down_stop  stall from the arbiter control input
//   go_right                demux token, [1]=valid, [0]=1 exit / 0 loop back
//   go_right_down_stop      stall from the demux control input
//   done                    completion token, 2'b11 when valid
//   done_down_stop          stall from the done consumer
//   busy                    high in any state except IDLE
//   iter                    current 1-based iteration, 0 when idle
module loop_ctrl #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W:0]   count_in,
  output logic             count_back_stop,
  output logic [1:0]       choose_right,
  input  logic             choose_right_down_stop,
  output logic [1:0]       go_right,
  input  logic             go_right_down_stop,
  output logic [1:0]       done,
  input  logic             done_down_stop,
  output logic             busy,
  output logic [CNT_W-1:0] iter
);

  localparam logic [1:0] TOK_NONE = 2'b00;
  localparam logic [1:0] TOK_ZERO = 2'b10;
  localparam logic [1:0] TOK_ONE  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENTER,
    ST_LOOP,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic [1:0]       choose_q, choose_d;
  logic [1:0]       go_q, go_d;
  logic [1:0]       done_q, done_d;
  logic             ch_sent_q, ch_sent_d;
  logic             go_sent_q, go_sent_d;
  logic             busy_q, busy_d;

  logic             ch_xfer, go_xfer, done_xfer;
  logic             load_set, load_last;

  assign ch_xfer   = choose_q[1] & ~choose_right_down_stop;
  assign go_xfer   = go_q[1] & ~go_right_down_stop;
  assign done_xfer = done_q[1] & ~done_down_stop;

  assign count_back_stop = (state_q != ST_IDLE);

  // Next-state and token sequencing.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    iter_d    = iter_q;
    choose_d  = choose_q;
    go_d      = go_q;
    done_d    = done_q;
    ch_sent_d = ch_sent_q;
    go_sent_d = go_sent_q;
    load_set  = 1'b0;
    load_last = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (count_in[CNT_W]) begin
          // A zero count still runs one pass so the data token always exits.
          n_d       = (count_in[CNT_W-1:0] == '0) ? CNT_W'(1) : count_in[CNT_W-1:0];
          iter_d    = CNT_W'(1);
          choose_d  = TOK_ONE;
          ch_sent_d = 1'b0;
          go_sent_d = 1'b0;
          state_d   = ST_ENTER;
        end
      end
      ST_ENTER: begin
        if (ch_xfer) begin
          state_d   = ST_LOOP;
          load_set  = 1'b1;
          load_last = (n_q == CNT_W'(1));
        end
      end
      ST_LOOP: begin
        // An iteration completes when every channel has transferred, whether
        // earlier (sent flag) or on this very edge.
        if ((ch_sent_q | ch_xfer) && (go_sent_q | go_xfer)) begin
          if (iter_q != n_q) begin
            iter_d    = iter_q + CNT_W'(1);
            load_set  = 1'b1;
            load_last = ((iter_q + CNT_W'(1)) == n_q);
          end else begin
            choose_d = TOK_NONE;
            go_d     = TOK_NONE;
            done_d   = TOK_ONE;
            state_d  = ST_DONE;
          end
        end else begin
          if (ch_xfer) begin
            choose_d  = TOK_NONE;
            ch_sent_d = 1'b1;
          end
          if (go_xfer) begin
            go_d      = TOK_NONE;
            go_sent_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (done_xfer) begin
          done_d  = TOK_NONE;
          iter_d  = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The last iteration carries no arbiter token, so its channel starts sent.
    if (load_set) begin
      go_d      = load_last ? TOK_ONE : TOK_ZERO;
      choose_d  = load_last ? TOK_NONE : TOK_ZERO;
      ch_sent_d = load_last;
      go_sent_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      n_q       <= '0;
      iter_q    <= '0;
      choose_q  <= TOK_NONE;
      go_q      <= TOK_NONE;
      done_q    <= TOK_NONE;
      ch_sent_q <= 1'b0;
      go_sent_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      iter_q    <= iter_d;
      choose_q  <= choose_d;
      go_q      <= go_d;
      done_q    <= done_d;
      ch_sent_q <= ch_sent_d;
      go_sent_q <= go_sent_d;
      busy_q    <= busy_d;
    end
  end

  assign choose_right = choose_q;
  assign go_right     = go_q;
  assign done         = done_q;
  assign busy         = busy_q;
  assign iter         = iter_q;

endmodule

// File: tb/tb_loop_ctrl.sv
// tb_loop_ctrl: self-checking bench for loop_ctrl. A token-count model predicts
// every output on every cycle; directed timelines pin exact latencies.
module tb_loop_ctrl;

  localparam int CNT_W = 8;
  localparam logic [7:0] GO_SIGNAL = 8'h5A;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [CNT_W:0]   count_in;
  logic             count_back_stop;
  logic [1:0]       choose_right;
  logic             choose_right_down_stop;
  logic [1:0]       go_right;
  logic             go_right_down_stop;
  logic [1:0]       done;
  logic             done_down_stop;
  logic             busy;
  logic [CNT_W-1:0] iter;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: sequence length and how many tokens each channel has transferred.
  bit m_busy = 1'b0;
  int m_n = 0, m_ch = 0, m_go = 0;

  loop_ctrl #(.CNT_W(CNT_W)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .count_in               (count_in),
    .count_back_stop        (count_back_stop),
    .choose_right           (choose_right),
    .choose_right_down_stop (choose_right_down_stop),
    .go_right               (go_right),
    .go_right_down_stop     (go_right_down_stop),
    .done                   (done),
    .done_down_stop         (done_down_stop),
    .busy                   (busy),
    .iter                   (iter)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Per-cycle compare against the model, then advance the model by the
  // transfers that the upcoming edge will perform.
  always @(negedge clk) begin
    int  e_iter, t;
    bit  ch_v, go_v, dn_v;
    int  e_ch, e_go;
    if (!rst_n) begin
      m_busy = 1'b0; m_n = 0; m_ch = 0; m_go = 0;
      chk("rst_choose", int'(choose_right), 0);
      chk("rst_go", int'(go_right), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_iter", int'(iter), 0);
      chk("rst_cbs", int'(count_back_stop), 0);
    end else begin
      ch_v = m_busy && (m_ch < m_n) && (m_ch == 0 || m_go >= m_ch - 1);
      go_v = m_busy && (m_go < m_n) && (m_ch >= m_go + 1);
      dn_v = m_busy && (m_go == m_n) && (m_ch == m_n);
      e_ch = ch_v ? ((m_ch == 0) ? 3 : 2) : 0;
      e_go = go_v ? ((m_go == m_n - 1) ? 3 : 2) : 0;
      if (!m_busy) e_iter = 0;
      else begin
        t = (m_go < m_ch - 1) ? m_go : m_ch - 1;
        t = t + 1;
        if (t > m_n) t = m_n;
        if (t < 1) t = 1;
        e_iter = t;
      end
      chk("model_choose", int'(choose_right), e_ch);
      chk("model_go", int'(go_right), e_go);
      chk("model_done", int'(done), dn_v ? 3 : 0);
      chk("model_busy", int'(busy), int'(m_busy));
      chk("model_cbs", int'(count_back_stop), int'(m_busy));
      chk("model_iter", int'(iter), e_iter);
      if (m_busy) begin
        if (ch_v && !choose_right_down_stop) m_ch++;
        if (go_v && !go_right_down_stop) m_go++;
        if (dn_v && !done_down_stop) m_busy = 1'b0;
      end else if (count_in[CNT_W]) begin
        m_busy = 1'b1;
        m_n  = (count_in[CNT_W-1:0] == 0) ? 1 : int'(count_in[CNT_W-1:0]);
        m_ch = 0;
        m_go = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer a count (called at posedge+1); returns at the start of cycle 1.
  task automatic send_count(input int n);
    bit ok;
    ok = 1'b0;
    count_in = {1'b1, CNT_W'(n)};
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!count_back_stop) begin ok = 1'b1; break; end
      cyc();
    end
    chk("count_accept", int'(ok), 1);
    cyc();
    count_in = '0;
  endtask

  task automatic wait_idle(input int max_cyc);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    chk("idle_in_time", int'(ok), 1);
    cyc();
  endtask

  task automatic run_random(input int n);
    bit ok;
    ok = 1'b0;
    send_count(n);
    for (int c = 0; c < 3000; c++) begin
      choose_right_down_stop = 1'($urandom_range(0, 1));
      go_right_down_stop     = 1'($urandom_range(0, 1));
      done_down_stop         = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
      cyc();
    end
    chk("rand_idle", int'(ok), 1);
    cyc();
    choose_right_down_stop = 1'b0;
    go_right_down_stop     = 1'b0;
    done_down_stop         = 1'b0;
  endtask

  // Arbiter + demux around the controller, one data token circulating.
  task automatic run_closed_loop(input int n);
    bit in_v, fb_v, dm_v, chx, gox, ok;
    logic [7:0] in_d, fb_d, dm_d, out_d;
    int passes, right_cnt, late_tokens;
    in_v = 1'b1; in_d = GO_SIGNAL; fb_v = 1'b0; dm_v = 1'b0;
    fb_d = '0; dm_d = '0; out_d = '0;
    passes = 0; right_cnt = 0; late_tokens = 0; ok = 1'b0;
    send_count(n);
    for (int c = 0; c < 200; c++) begin
      choose_right_down_stop = choose_right[1] &&
                               !((choose_right[0] ? in_v : fb_v) && !dm_v);
      go_right_down_stop     = go_right[1] && !dm_v;
      @(negedge clk);
      chx = choose_right[1] && !choose_right_down_stop;
      gox = go_right[1] && !go_right_down_stop;
      if (gox) begin
        passes++;
        if (go_right[0]) begin right_cnt++; out_d = dm_d; end
        else begin fb_v = 1'b1; fb_d = dm_d; end
        dm_v = 1'b0;
      end
      if (chx) begin
        if (choose_right[0]) begin dm_d = in_d; in_v = 1'b0; end
        else begin dm_d = fb_d; fb_v = 1'b0; end
        dm_v = 1'b1;
      end
      if (!busy) begin ok = 1'b1; break; end
      cyc();
    end
    chk("cl_finished", int'(ok), 1);
    for (int c = 0; c < 4; c++) begin
      cyc();
      choose_right_down_stop = 1'b0;
      go_right_down_stop     = 1'b0;
      @(negedge clk);
      if (choose_right[1] || go_right[1]) late_tokens++;
    end
    cyc();
    chk("cl_passes", passes, n);
    chk("cl_right_cnt", right_cnt, 1);
    chk("cl_payload", int'(out_d), int'(GO_SIGNAL));
    chk("cl_left_idle", int'(fb_v), 0);
    chk("cl_demux_empty", int'(dm_v), 0);
    chk("cl_input_used", int'(in_v), 0);
    chk("cl_late_tokens", late_tokens, 0);
  endtask

  initial begin
    bit found;
    rst_n = 1'b0;
    count_in = '0;
    choose_right_down_stop = 1'b0;
    go_right_down_stop     = 1'b0;
    done_down_stop         = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("init_busy", int'(busy), 0);
    chk("init_iter", int'(iter), 0);
    chk("init_cbs", int'(count_back_stop), 0);
    cyc();

    // N=3, no stalls.
    send_count(3);
    @(negedge clk); chk("n3_c1_choose", int'(choose_right), 3);
    @(negedge clk); chk("n3_c2_choose", int'(choose_right), 2);
    chk("n3_c2_go", int'(go_right), 2);
    @(negedge clk); chk("n3_c3_choose", int'(choose_right), 2);
    chk("n3_c3_go", int'(go_right), 2);
    chk("n3_c3_iter", int'(iter), 2);
    @(negedge clk); chk("n3_c4_choose", int'(choose_right), 0);
    chk("n3_c4_go", int'(go_right), 3);
    chk("n3_c4_iter", int'(iter), 3);
    @(negedge clk); chk("n3_c5_done", int'(done), 3);
    @(negedge clk); chk("n3_c6_busy", int'(busy), 0);
    chk("n3_c6_iter", int'(iter), 0);
    cyc();

    // N=0 runs as a single pass.
    send_count(0);
    @(negedge clk); chk("n0_c1_choose", int'(choose_right), 3);
    @(negedge clk); chk("n0_c2_go", int'(go_right), 3);
    chk("n0_c2_choose", int'(choose_right), 0);
    @(negedge clk); chk("n0_c3_done", int'(done), 3);
    chk("n0_c3_go", int'(go_right), 0);
    @(negedge clk); chk("n0_c4_busy", int'(busy), 0);
    cyc();

    // N=2 with the demux stalled for three cycles in iteration 1.
    send_count(2);
    @(negedge clk); chk("st_c1_choose", int'(choose_right), 3);
    cyc(); go_right_down_stop = 1'b1;
    @(negedge clk); chk("st_c2_choose", int'(choose_right), 2);
    chk("st_c2_go", int'(go_right), 2);
    cyc();
    @(negedge clk); chk("st_c3_choose", int'(choose_right), 0);
    chk("st_c3_go", int'(go_right), 2);
    chk("st_c3_iter", int'(iter), 1);
    cyc();
    @(negedge clk); chk("st_c4_go", int'(go_right), 2);
    cyc(); go_right_down_stop = 1'b0;
    @(negedge clk); chk("st_c5_go", int'(go_right), 2);
    chk("st_c5_iter", int'(iter), 1);
    cyc();
    @(negedge clk); chk("st_c6_iter", int'(iter), 2);
    chk("st_c6_go", int'(go_right), 3);
    chk("st_c6_choose", int'(choose_right), 0);
    wait_idle(20);

    // Count offered while busy, with the done consumer stalled.
    send_count(1);
    count_in = {1'b1, CNT_W'(5)};
    done_down_stop = 1'b1;
    @(negedge clk); chk("bz_c1_cbs", int'(count_back_stop), 1);
    cyc(); @(negedge clk); chk("bz_c2_go", int'(go_right), 3);
    cyc(); @(negedge clk); chk("bz_c3_done", int'(done), 3);
    cyc(); @(negedge clk); chk("bz_c4_done", int'(done), 3);
    chk("bz_c4_cbs", int'(count_back_stop), 1);
    cyc(); @(negedge clk); chk("bz_c5_done", int'(done), 3);
    cyc(); done_down_stop = 1'b0;
    @(negedge clk); chk("bz_c6_done", int'(done), 3);
    cyc(); @(negedge clk); chk("bz_c7_busy", int'(busy), 0);
    chk("bz_c7_cbs", int'(count_back_stop), 0);
    chk("bz_c7_done", int'(done), 0);
    cyc(); count_in = '0;
    @(negedge clk); chk("bz_c8_busy", int'(busy), 1);
    chk("bz_c8_choose", int'(choose_right), 3);
    chk("bz_c8_iter", int'(iter), 1);
    wait_idle(50);

    // Maximum count must reach iter=255 without wrapping.
    send_count(255);
    found = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (go_right == 2'b11) begin found = 1'b1; break; end
    end
    chk("max_last_seen", int'(found), 1);
    chk("max_iter", int'(iter), 255);
    wait_idle(20);

    // Random stalls on all channels.
    run_random(7);
    run_random(2);
    run_random(1);

    // Closed loop through arbiter and demux.
    run_closed_loop(4);

    // Asynchronous reset in the middle of a loop.
    send_count(6);
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", int'(busy), 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_choose", int'(choose_right), 0);
    chk("arst_go", int'(go_right), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_iter", int'(iter), 0);
    chk("arst_cbs", int'(count_back_stop), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    cyc();
    send_count(2);
    @(negedge clk); chk("post_rst_choose", int'(choose_right), 3);
    @(negedge clk); chk("post_rst_go", int'(go_right), 2);
    wait_idle(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/loop_ctrl.md
Name: loop_ctrl

Overview:
Sequencing controller for a counted dataflow loop built from simple_arbiter_wr (loop entry/merge) and simple_demux_wr (loop exit/branch). It accepts an iteration-count token and emits the exact sequence of choose_right tokens (arbiter) and go_right tokens (demux). One data token then enters on the arbiter right input, circulates N times, and exits on the demux right path. A done token is emitted when the sequence is fully issued.

Parameters:
CNT_W, 8, width of the iteration count and iter index; max N = 2^CNT_W-1

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  asynchronous active-low reset
count_in  input  CNT_W+1  count token; MSB=valid, [CNT_W-1:0]=N
count_back_stop  output  1  stall to count producer
choose_right  output  2  arbiter control token; [1]=valid, [0]=1 right/entry, 0 left/feedback
choose_right_down_stop  input  1  stall from arbiter control input
go_right  output  2  demux control token; [1]=valid, [0]=1 exit, 0 loop back
go_right_down_stop  input  1  stall from demux control input
done  output  2  completion token; 2'b11 when valid
done_down_stop  input  1  stall from done consumer
busy  output  1  1 in any state except IDLE
iter  output  CNT_W  current 1-based iteration; 0 in IDLE

Behaviour:
- Handshake on every channel: transfer on a posedge where valid=1 and stop=0. A producer holds its word stable while stalled. All token outputs are registered.
- rst_n low, asynchronously: state=IDLE, choose_right=go_right=done=2'b00, iter=0, N register=0, sent flags cleared. Reset mid-sequence abandons the sequence with no partial tokens afterwards.
- count_back_stop = (state!=IDLE), combinational.
- IDLE: on a count transfer, latch N (N=0 is treated as 1), set iter=1, load choose_right=2'b11, and go to ENTER. Latency: count accepted at edge k, entry token visible in cycle k+1.
- ENTER: hold choose_right=11 until transferred. On that edge go to LOOP and load the tokens for iter=1.
- LOOP, token set for iteration i:
  - i<N: go_right=2'b10 and choose_right=2'b10, issued in parallel.
  - i=N: go_right=2'b11 and choose_right=2'b00 (no arbiter token).
- Each channel has a sent flag. When a channel transfers, its output drops to 2'b00 on that edge and its flag sets.
- The edge where the last outstanding channel of iteration i transfers does the following:
  - i<N: iter=i+1, load the next token set, clear the flags.
  - i=N: go to DONE, load done=2'b11.
- Both channels transferring on the same edge counts as completion, so back-to-back iterations run at 1 per cycle with no bubbles.
- Total tokens per sequence: N choose_right (one 11, then N-1 of 10) and N go_right (N-1 of 10, then one 11).
- DONE: hold done=11 until transferred. On that edge done goes to 00, iter goes to 0, state goes to IDLE. A new count can be accepted from the following cycle (1-cycle bubble).
- Stalls on one channel never block, reorder or duplicate tokens on the other channel within the same iteration.
- A count token presented while busy is stalled, never dropped.
- N=2^CNT_W-1 must not wrap iter.

Test Plan:
- Reset: rst_n=0 mid-LOOP, asynchronously -> all token outputs 00, busy=0, iter=0, count_back_stop=0; after release a fresh N=2 runs correctly.
- N=3, no stalls, count accepted edge 0:
  - cycle 1: choose=11.
  - cycles 2-3: go=10, choose=10.
  - cycle 4: go=11, choose=00.
  - cycle 5: done=11.
  - cycle 6: IDLE.
- N=0 -> handled as N=1: choose=11, then go=11, then done=11; no 10 tokens appear.
- N=2 with go_right_down_stop=1 for 3 cycles in iteration 1:
  - choose=10 transfers and drops to 00.
  - go=10 is held stable through the stall.
  - iteration 2 loads only on the go transfer edge.
- Count offered while busy -> count_back_stop=1 and the token stays pending; it is accepted the cycle after the done transfer. With done_down_stop=1, done=11 is held and the new count stays stalled.
- Closed loop with arbiter+demux wrappers, N=4, data {1,GO_SIGNAL} on arbiter right -> exactly one token on the demux right_path after 4 passes; left path idle afterwards.
